execute_stage: RTL

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/rv32i_pkg.sv | 58 +++++
 rtl/alu.sv | 30 +++
 rtl/execute_stage.sv | 126 ++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I execute-stage types: ALU ops, forwarding selects, jump and
// result-source encodings, branch funct3 codes and the forwarding mux helper.
`default_nettype none

package rv32i_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10,
    FWD_RSVD = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    JUMP_NONE = 2'b00,
    JUMP_JAL  = 2'b01,
    JUMP_JALR = 2'b10
  } jump_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Reserved select 11 falls back to the register-file operand.
  function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                          input logic [31:0] rf,
                                          input logic [31:0] wb,
                                          input logic [31:0] mem);
    case (fwd_sel_e'(sel))
      FWD_WB:  return wb;
      FWD_MEM: return mem;
      default: return rf;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu.sv
// 32-bit RV32I ALU: add/sub/and/or/xor/slt/sll/srl, all wrap-around.
`default_nettype none

module alu
  import rv32i_pkg::*;
(
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [2:0]  ALUControl,
  output logic [31:0] ALUResult
);

  always_comb begin
    ALUResult = '0;
    case (alu_op_e'(ALUControl))
      ALU_ADD: ALUResult = SrcA + SrcB;
      ALU_SUB: ALUResult = SrcA - SrcB;
      ALU_AND: ALUResult = SrcA & SrcB;
      ALU_OR:  ALUResult = SrcA | SrcB;
      ALU_XOR: ALUResult = SrcA ^ SrcB;
      ALU_SLT: ALUResult = {31'b0, ($signed(SrcA) < $signed(SrcB))};
      ALU_SLL: ALUResult = SrcA << SrcB[4:0];
      ALU_SRL: ALUResult = SrcA >> SrcB[4:0];
      default: ALUResult = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch resolution, jump
// target generation and the E/M pipeline register with retired-instruction count.
`default_nettype none

module execute_stage
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ValidE,
  input  logic        RegWriteE,
  input  logic [1:0]  ResultSrcE,
  input  logic        MemWriteE,
  input  logic [1:0]  JumpE,
  input  logic        BranchE,
  input  logic [2:0]  Funct3E,
  input  logic [2:0]  ALUControlE,
  input  logic        ALUSrcE,
  input  logic [31:0] RD1E,
  input  logic [31:0] RD2E,
  input  logic [31:0] PCE,
  input  logic [31:0] ImmExtE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RdE,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic        StallM,
  input  logic        FlushM,
  input  logic [31:0] ResultW,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        ValidM,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic [1:0]  ResultSrcM,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [31:0] PCPlus4M,
  output logic [4:0]  RdM,
  output logic [31:0] InstretM
);

  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [31:0] src_b;
  logic [31:0] alu_result;
  logic [31:0] target_sum;
  logic        is_jalr;
  logic        branch_taken;
  logic        capture;

  assign fwd_a = fwd_mux(ForwardAE, RD1E, ResultW, ALUResultM);
  assign fwd_b = fwd_mux(ForwardBE, RD2E, ResultW, ALUResultM);
  assign src_b = ALUSrcE ? ImmExtE : fwd_b;

  alu u_alu (
    .SrcA       (fwd_a),
    .SrcB       (src_b),
    .ALUControl (ALUControlE),
    .ALUResult  (alu_result)
  );

  // Comparator always sees the register operands, never the immediate.
  always_comb begin
    branch_taken = 1'b0;
    case (Funct3E)
      F3_BEQ:  branch_taken = (fwd_a == fwd_b);
      F3_BNE:  branch_taken = (fwd_a != fwd_b);
      F3_BLT:  branch_taken = ($signed(fwd_a) <  $signed(fwd_b));
      F3_BGE:  branch_taken = ($signed(fwd_a) >= $signed(fwd_b));
      F3_BLTU: branch_taken = (fwd_a <  fwd_b);
      F3_BGEU: branch_taken = (fwd_a >= fwd_b);
      default: branch_taken = 1'b0;
    endcase
  end

  assign is_jalr    = (JumpE == JUMP_JALR);
  assign target_sum = (is_jalr ? fwd_a : PCE) + ImmExtE;
  assign PCTargetE  = is_jalr ? {target_sum[31:1], 1'b0} : target_sum;
  assign PCSrcE     = ValidE & ((JumpE != JUMP_NONE) | (BranchE & branch_taken));

  assign capture = ValidE & ~StallM & ~FlushM;

  // Flush takes priority over stall so a bubble always replaces a held slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ValidM     <= 1'b0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 2'b00;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      RdM        <= '0;
    end else if (FlushM) begin
      ValidM     <= 1'b0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 2'b00;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      RdM        <= '0;
    end else if (!StallM) begin
      ValidM     <= ValidE;
      RegWriteM  <= RegWriteE & ValidE;
      MemWriteM  <= MemWriteE & ValidE;
      ResultSrcM <= ResultSrcE;
      ALUResultM <= alu_result;
      WriteDataM <= fwd_b;
      PCPlus4M   <= PCPlus4E;
      RdM        <= RdE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      InstretM <= '0;
    end else if (capture) begin
      InstretM <= InstretM + 32'd1;
    end
  end

endmodule

`default_nettype wire
